// File: rtl/alu_cmd_sequencer.sv
// Command front-end for a 4-bit combinational ALU: registers operands/opcode, captures the
// result with status flags and queues it in a show-ahead FIFO for a downstream consumer.
module alu_cmd_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_a,
  input  logic [3:0]    in_b,
  input  logic [2:0]    in_sel,
  output logic [3:0]    alu_a,
  output logic [3:0]    alu_b,
  output logic [2:0]    alu_sel,
  input  logic [4:0]    alu_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [4:0]    out_result,
  output logic [2:0]    out_sel,
  output logic          out_zero,
  output logic          out_carry,
  output logic          out_divz,
  output logic [CW-1:0] fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = 11;

  typedef enum logic {StIdle, StExec} state_e;

  state_e        r_state, w_state_next;
  logic [3:0]    r_alu_a, r_alu_b;
  logic [2:0]    r_alu_sel;
  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;

  logic          w_accept, w_push, w_pop;
  logic          w_divz, w_carry, w_zero;
  logic [4:0]    w_result;
  logic [EW-1:0] w_entry, w_head;

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    case (r_state)
      StIdle: begin
        in_ready = (r_count < CW'(DEPTH));
        if (in_valid && in_ready) w_state_next = StExec;
      end
      StExec:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  assign w_accept = (r_state == StIdle) && in_valid && in_ready;
  assign w_push   = (r_state == StExec);
  assign w_pop    = out_valid && out_ready;

  // Divide/mod by zero replaces the undefined ALU output with all-ones.
  assign w_divz   = ((r_alu_sel == 3'b011) || (r_alu_sel == 3'b100)) && (r_alu_b == 4'd0);
  assign w_result = w_divz ? 5'h1F : alu_out;
  assign w_zero   = (w_result == 5'd0);

  always_comb begin
    w_carry = 1'b0;
    case (r_alu_sel)
      3'b001:  w_carry = alu_out[4];
      3'b010:  w_carry = (r_alu_a < r_alu_b);
      3'b101:  w_carry = r_alu_a[3];
      3'b110:  w_carry = r_alu_a[0];
      default: w_carry = 1'b0;
    endcase
  end

  assign w_entry = {w_result, r_alu_sel, w_zero, w_carry, w_divz};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_alu_a   <= 4'd0;
      r_alu_b   <= 4'd0;
      r_alu_sel <= 3'd0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_alu_a   <= in_a;
        r_alu_b   <= in_b;
        r_alu_sel <= in_sel;
      end
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) r_mem[r_wptr] <= w_entry;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head     = r_mem[r_rptr];
  assign out_valid  = (r_count != '0);
  assign fifo_count = r_count;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_sel    = r_alu_sel;

  assign {out_result, out_sel, out_zero, out_carry, out_divz} = out_valid ? w_head : '0;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural 4-bit ALU model on alu_out.
module tb_alu_cmd_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  localparam logic [2:0] OpPass = 3'b000, OpAdd = 3'b001, OpSub = 3'b010, OpDiv = 3'b011;
  localparam logic [2:0] OpMod  = 3'b100, OpShl = 3'b101, OpShr = 3'b110, OpGt  = 3'b111;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]    in_a, in_b, alu_a, alu_b;
  logic [2:0]    in_sel, alu_sel, out_sel;
  logic [4:0]    alu_out, out_result;
  logic          out_zero, out_carry, out_divz;
  logic [CW-1:0] fifo_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [4:0] drain_exp [4] = '{5'd3, 5'd4, 5'd5, 5'd6};

  alu_cmd_sequencer #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_sel     (in_sel),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_out    (alu_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_sel    (out_sel),
    .out_zero   (out_zero),
    .out_carry  (out_carry),
    .out_divz   (out_divz),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  // Divide/mod by zero returns junk so the forced 5'h1F is observable.
  always_comb begin
    alu_out = 5'd0;
    case (alu_sel)
      OpPass:  alu_out = {1'b0, alu_a};
      OpAdd:   alu_out = {1'b0, alu_a} + {1'b0, alu_b};
      OpSub:   alu_out = {1'b0, alu_a} - {1'b0, alu_b};
      OpDiv:   alu_out = (alu_b == 4'd0) ? 5'h0A : {1'b0, alu_a / alu_b};
      OpMod:   alu_out = (alu_b == 4'd0) ? 5'h0A : {1'b0, alu_a % alu_b};
      OpShl:   alu_out = {alu_a, 1'b0};
      OpShr:   alu_out = {2'b00, alu_a[3:1]};
      default: alu_out = {4'd0, alu_a > alu_b};
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns just after the accept edge (DUT in EXEC).
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel);
    in_a     = a;
    in_b     = b;
    in_sel   = sel;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !in_ready; i++) tick();
    check("in_ready_wait", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic exec(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel);
    send(a, b, sel);
    tick();
  endtask

  task automatic check_head(input string tag, input logic [4:0] res, input logic [2:0] sel,
                            input logic zero, input logic carry, input logic divz);
    check({tag, "_valid"},  32'(out_valid),  1);
    check({tag, "_result"}, 32'(out_result), 32'(res));
    check({tag, "_sel"},    32'(out_sel),    32'(sel));
    check({tag, "_zero"},   32'(out_zero),   32'(zero));
    check({tag, "_carry"},  32'(out_carry),  32'(carry));
    check({tag, "_divz"},   32'(out_divz),   32'(divz));
  endtask

  task automatic pop();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = 4'd0; in_b = 4'd0; in_sel = 3'd0;
    tick(); tick();
    check("rst_valid",  32'(out_valid),  0);
    check("rst_count",  32'(fifo_count), 0);
    check("rst_alu_a",  32'(alu_a),      0);
    check("rst_alu_sel", 32'(alu_sel),   0);
    check("rst_result", 32'(out_result), 0);
    check("rst_ready",  32'(in_ready),   1);
    rst_n = 1'b1;
    tick();

    // Single commands, checking latency and no bypass.
    send(4'hF, 4'h1, OpAdd);
    check("exec_ready", 32'(in_ready),  0);
    check("no_bypass",  32'(out_valid), 0);
    tick();
    check_head("add_f1", 5'h10, OpAdd, 1'b0, 1'b1, 1'b0);
    check("add_count", 32'(fifo_count), 1);
    pop();
    check("pop_count", 32'(fifo_count), 0);

    exec(4'h3, 4'h5, OpSub); check_head("sub_35", 5'h1E, OpSub, 1'b0, 1'b1, 1'b0); pop();
    exec(4'h5, 4'h5, OpSub); check_head("sub_55", 5'h00, OpSub, 1'b1, 1'b0, 1'b0); pop();
    exec(4'h7, 4'h0, OpDiv); check_head("div_70", 5'h1F, OpDiv, 1'b0, 1'b0, 1'b1); pop();
    exec(4'h9, 4'h0, OpMod); check_head("mod_90", 5'h1F, OpMod, 1'b0, 1'b0, 1'b1); pop();
    exec(4'h9, 4'h2, OpDiv); check_head("div_92", 5'h04, OpDiv, 1'b0, 1'b0, 1'b0); pop();
    check("hold_alu_a",   32'(alu_a),   9);
    check("hold_alu_b",   32'(alu_b),   2);
    check("hold_alu_sel", 32'(alu_sel), 3);

    // Fill the FIFO with the consumer stalled.
    for (int i = 0; i < 4; i++) exec(4'(i + 1), 4'h1, OpAdd);
    check("full_count", 32'(fifo_count), 4);
    check("full_ready", 32'(in_ready),   0);
    in_a = 4'h5; in_b = 4'h1; in_sel = OpAdd; in_valid = 1'b1;
    tick(); tick();
    check("stall_count", 32'(fifo_count), 4);
    check("stall_head",  32'(out_result), 2);
    pop();
    check("freed_count", 32'(fifo_count), 3);
    check("freed_ready", 32'(in_ready),   1);
    check("freed_head",  32'(out_result), 3);
    tick();
    in_valid = 1'b0;
    check("fifth_exec", 32'(in_ready), 0);
    tick();
    check("refill_count", 32'(fifo_count), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_%0d", i), 32'(out_result), 32'(drain_exp[i]));
      pop();
    end
    check("drained_count", 32'(fifo_count), 0);
    check("drained_valid", 32'(out_valid),  0);
    pop();
    check("empty_pop_count", 32'(fifo_count), 0);

    // Streaming with the consumer always ready.
    out_ready = 1'b1;
    send(4'h8, 4'h0, OpShl); check("st_shl_c0", 32'(fifo_count), 0); tick();
    check("st_shl_c1", 32'(fifo_count), 1);
    check_head("shl_8", 5'h10, OpShl, 1'b0, 1'b1, 1'b0);
    send(4'h3, 4'h0, OpShr); check("st_shr_c0", 32'(fifo_count), 0); tick();
    check_head("shr_3", 5'h01, OpShr, 1'b0, 1'b1, 1'b0);
    send(4'h5, 4'h3, OpGt);  check("st_gt_c0", 32'(fifo_count), 0); tick();
    check_head("gt_53", 5'h01, OpGt, 1'b0, 1'b0, 1'b0);
    send(4'h7, 4'h2, OpPass); tick();
    check_head("pass_7", 5'h07, OpPass, 1'b0, 1'b0, 1'b0);
    tick();
    check("st_end_count", 32'(fifo_count), 0);
    out_ready = 1'b0;

    // Reset while a command is executing with two entries queued.
    exec(4'h1, 4'h2, OpAdd);
    exec(4'h3, 4'h4, OpAdd);
    check("pre_rst_count", 32'(fifo_count), 2);
    send(4'h5, 4'h6, OpAdd);
    rst_n = 1'b0;
    tick();
    check("mid_rst_valid", 32'(out_valid),  0);
    check("mid_rst_count", 32'(fifo_count), 0);
    check("mid_rst_alu_a", 32'(alu_a),      0);
    check("mid_rst_alu_b", 32'(alu_b),      0);
    check("mid_rst_sel",   32'(alu_sel),    0);
    check("mid_rst_ready", 32'(in_ready),   1);
    rst_n = 1'b1;
    tick(); tick();
    check("post_rst_count",  32'(fifo_count), 0);
    check("post_rst_valid",  32'(out_valid),  0);
    check("post_rst_result", 32'(out_result), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
